uart_cmd_ctrl: RTL and testbench

Command controller for the debug UART. It consumes bytes from the `UART_Rx` receiver and parses fixed-length 5-byte command frames. It executes single-byte register writes and reads on the watch's internal register bus, and sequences the response bytes (ACK/NAK, read data) into a UART transmitter through its data-valid / active / done handshake. The block sits between the UART PHY pair and the register file and is the only master of the transmitter.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_timeout_cnt.sv | 44 ++++
 rtl/uart_cmd_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the debug UART command controller and
// its testbenches.
//   state_e      - command controller FSM states
//   *_BYTE/CMD_* - frame sync, response codes and command opcodes
//   FRAME_LEN    - bytes per command frame (SYNC, CMD, ADDR, DATA, CHK)
//   frame_chk_ok - frame checksum test (CHK = CMD ^ ADDR ^ DATA)
package uart_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_GET_CMD,
      ST_GET_ADDR,
      ST_GET_DATA,
      ST_GET_CHK,
      ST_EXEC,
      ST_RD_WAIT,
      ST_TX_ACK,
      ST_TX_NAK,
      ST_TX_DATA,
      ST_TX_ACK_WAIT,
      ST_TX_NAK_WAIT,
      ST_TX_DATA_WAIT
   } state_e;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;
   localparam logic [7:0] CMD_WR    = 8'h01;
   localparam logic [7:0] CMD_RD    = 8'h02;

   localparam int unsigned FRAME_LEN = 5;

   function automatic logic frame_chk_ok(input logic [7:0] cmd,
                                         input logic [7:0] addr,
                                         input logic [7:0] data,
                                         input logic [7:0] chk);
      return ((cmd ^ addr ^ data) == chk);
   endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: inter-byte timeout counter.
//   clk, rst - system clock, async active-high reset
//   clr_i    - synchronous clear to 0 (wins over en_i)
//   en_i     - count enable
//   tc_o     - high while enabled and the count sits at TIMEOUT_CLKS-1
// TIMEOUT_CLKS must be at least 2.
module uart_timeout_cnt #(
   parameter int unsigned TIMEOUT_CLKS = 4340
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == CNT_LAST);
   assign tc_o    = en_i && at_last;

   // Hold at the terminal value so the count can never wrap back to 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !at_last) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: debug UART command controller. Parses 5-byte frames
// (A5, CMD, ADDR, DATA, CHK), performs one register write or read and
// answers ACK/NAK (+ read data) through the transmitter handshake.
//   clk, rst                     - system clock, async active-high reset
//   i_RX_DV, i_RX_Byte           - received byte strobe and data
//   o_TX_DV, o_TX_Byte           - transmit start pulse and byte
//   i_TX_Active, i_TX_Done       - transmitter busy / end-of-byte pulse
//   o_Reg_Wr, o_Reg_Rd           - register write / read strobes
//   o_Reg_Addr, o_Reg_WData      - register address / write data
//   i_Reg_RData                  - read data, valid 1 cycle after o_Reg_Rd
//   o_Busy                       - controller not in IDLE
//   o_Err_Timeout, o_Err_Overrun - partial frame abandoned / byte dropped
//
// state           | meaning
// ----------------+----------------------------------------------------
// ST_IDLE         | waiting for SYNC, other bytes discarded
// ST_GET_CMD      | waiting for CMD byte
// ST_GET_ADDR     | waiting for ADDR byte
// ST_GET_DATA     | waiting for DATA byte
// ST_GET_CHK      | waiting for CHK byte
// ST_EXEC         | register strobe cycle, choose response
// ST_RD_WAIT      | capture register read data
// ST_TX_ACK       | ACK pending, transmitter still busy
// ST_TX_NAK       | NAK pending, transmitter still busy
// ST_TX_DATA      | read data pending, transmitter still busy
// ST_TX_ACK_WAIT  | ACK on the line, waiting for i_TX_Done
// ST_TX_NAK_WAIT  | NAK on the line, waiting for i_TX_Done
// ST_TX_DATA_WAIT | read data on the line, waiting for i_TX_Done
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CLKS = 4340
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   input  logic       i_TX_Active,
   input  logic       i_TX_Done,
   output logic       o_Reg_Wr,
   output logic       o_Reg_Rd,
   output logic [7:0] o_Reg_Addr,
   output logic [7:0] o_Reg_WData,
   input  logic [7:0] i_Reg_RData,
   output logic       o_Busy,
   output logic       o_Err_Timeout,
   output logic       o_Err_Overrun
);

   state_e     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       tx_dv_q, tx_dv_d;
   logic       reg_wr_q, reg_wr_d;
   logic       reg_rd_q, reg_rd_d;
   logic       err_to_q, err_to_d;
   logic       err_ov_q, err_ov_d;
   logic       busy_q, busy_d;

   logic       in_get;
   logic       frame_ok;
   logic       tmo_tc;
   logic       tmo_clr;

   // Response launch request, resolved after the state case.
   logic       tx_want;
   logic [7:0] want_byte;
   state_e     want_wait;
   state_e     want_hold;

   assign in_get   = (state_q == ST_GET_CMD)  || (state_q == ST_GET_ADDR) ||
                     (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
   assign frame_ok = frame_chk_ok(cmd_q, addr_q, wdata_q, chk_q);
   assign tmo_clr  = i_RX_DV || ((state_d == ST_GET_CMD) && (state_q != ST_GET_CMD));

   uart_timeout_cnt #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clr_i (tmo_clr),
      .en_i  (in_get),
      .tc_o  (tmo_tc)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      chk_d     = chk_q;
      rdata_d   = rdata_q;
      tx_byte_d = tx_byte_q;
      tx_dv_d   = 1'b0;
      reg_wr_d  = 1'b0;
      reg_rd_d  = 1'b0;
      err_to_d  = 1'b0;
      err_ov_d  = 1'b0;
      tx_want   = 1'b0;
      want_byte = ACK_BYTE;
      want_wait = ST_TX_ACK_WAIT;
      want_hold = ST_TX_ACK;

      case (state_q)
         ST_IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = ST_GET_CMD;
         end
         ST_GET_CMD: begin
            if (i_RX_DV) begin
               cmd_d   = i_RX_Byte;
               state_d = ST_GET_ADDR;
            end
         end
         ST_GET_ADDR: begin
            if (i_RX_DV) begin
               addr_d  = i_RX_Byte;
               state_d = ST_GET_DATA;
            end
         end
         ST_GET_DATA: begin
            if (i_RX_DV) begin
               wdata_d = i_RX_Byte;
               state_d = ST_GET_CHK;
            end
         end
         ST_GET_CHK: begin
            if (i_RX_DV) begin
               chk_d   = i_RX_Byte;
               state_d = ST_EXEC;
               // Strobes are registered, so decide them here to land in EXEC.
               if (frame_chk_ok(cmd_q, addr_q, wdata_q, i_RX_Byte)) begin
                  reg_wr_d = (cmd_q == CMD_WR);
                  reg_rd_d = (cmd_q == CMD_RD);
               end
            end
         end
         ST_EXEC: begin
            if (frame_ok && (cmd_q == CMD_WR)) begin
               tx_want = 1'b1;
            end else if (frame_ok && (cmd_q == CMD_RD)) begin
               state_d = ST_RD_WAIT;
            end else begin
               tx_want   = 1'b1;
               want_byte = NAK_BYTE;
               want_wait = ST_TX_NAK_WAIT;
               want_hold = ST_TX_NAK;
            end
         end
         ST_RD_WAIT: begin
            rdata_d = i_Reg_RData;
            tx_want = 1'b1;
         end
         ST_TX_ACK: begin
            tx_want = 1'b1;
         end
         ST_TX_NAK: begin
            tx_want   = 1'b1;
            want_byte = NAK_BYTE;
            want_wait = ST_TX_NAK_WAIT;
            want_hold = ST_TX_NAK;
         end
         ST_TX_DATA: begin
            tx_want   = 1'b1;
            want_byte = rdata_q;
            want_wait = ST_TX_DATA_WAIT;
            want_hold = ST_TX_DATA;
         end
         ST_TX_ACK_WAIT: begin
            if (i_TX_Done) begin
               if (cmd_q == CMD_RD) begin
                  tx_want   = 1'b1;
                  want_byte = rdata_q;
                  want_wait = ST_TX_DATA_WAIT;
                  want_hold = ST_TX_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_TX_NAK_WAIT, ST_TX_DATA_WAIT: begin
            if (i_TX_Done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Launch straight into the *_WAIT state when the transmitter is free so
      // the pulse appears one cycle after the decision; otherwise park in the
      // matching TX_* state until it frees up.
      if (tx_want) begin
         if (!i_TX_Active) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = want_byte;
            state_d   = want_wait;
         end else begin
            state_d   = want_hold;
         end
      end

      // A byte on the terminal cycle was already taken above; only silence times out.
      if (in_get && tmo_tc && !i_RX_DV) begin
         err_to_d = 1'b1;
         state_d  = ST_IDLE;
      end

      if (i_RX_DV && !in_get && (state_q != ST_IDLE)) err_ov_d = 1'b1;

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         chk_q     <= '0;
         rdata_q   <= '0;
         tx_byte_q <= '0;
         tx_dv_q   <= 1'b0;
         reg_wr_q  <= 1'b0;
         reg_rd_q  <= 1'b0;
         err_to_q  <= 1'b0;
         err_ov_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         chk_q     <= chk_d;
         rdata_q   <= rdata_d;
         tx_byte_q <= tx_byte_d;
         tx_dv_q   <= tx_dv_d;
         reg_wr_q  <= reg_wr_d;
         reg_rd_q  <= reg_rd_d;
         err_to_q  <= err_to_d;
         err_ov_q  <= err_ov_d;
         busy_q    <= busy_d;
      end
   end

   assign o_TX_DV       = tx_dv_q;
   assign o_TX_Byte     = tx_byte_q;
   assign o_Reg_Wr      = reg_wr_q;
   assign o_Reg_Rd      = reg_rd_q;
   assign o_Reg_Addr    = addr_q;
   assign o_Reg_WData   = wdata_q;
   assign o_Busy        = busy_q;
   assign o_Err_Timeout = err_to_q;
   assign o_Err_Overrun = err_ov_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl with a
// behavioural transmitter (12-cycle byte) and a register model whose read
// data is addr ^ 0xE3, driven only in the cycle after o_Reg_Rd.
module tb_uart_cmd_ctrl;
   import uart_pkg::*;

   localparam int TO     = 40;
   localparam int TX_LEN = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_RX_DV = 1'b0;
   logic [7:0] i_RX_Byte = 8'h00;
   logic       o_TX_DV;
   logic [7:0] o_TX_Byte;
   logic       i_TX_Active = 1'b0;
   logic       i_TX_Done = 1'b0;
   logic       o_Reg_Wr, o_Reg_Rd;
   logic [7:0] o_Reg_Addr, o_Reg_WData;
   logic [7:0] i_Reg_RData = 8'hEE;
   logic       o_Busy, o_Err_Timeout, o_Err_Overrun;

   uart_cmd_ctrl #(.TIMEOUT_CLKS(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_RX_DV       (i_RX_DV),
      .i_RX_Byte     (i_RX_Byte),
      .o_TX_DV       (o_TX_DV),
      .o_TX_Byte     (o_TX_Byte),
      .i_TX_Active   (i_TX_Active),
      .i_TX_Done     (i_TX_Done),
      .o_Reg_Wr      (o_Reg_Wr),
      .o_Reg_Rd      (o_Reg_Rd),
      .o_Reg_Addr    (o_Reg_Addr),
      .o_Reg_WData   (o_Reg_WData),
      .i_Reg_RData   (i_Reg_RData),
      .o_Busy        (o_Busy),
      .o_Err_Timeout (o_Err_Timeout),
      .o_Err_Overrun (o_Err_Overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitors / models (sampled on negedge) ----------------
   int         wr_n = 0, rd_n = 0, to_n = 0, ov_n = 0;
   int         dvact_n = 0, unstable_n = 0;
   int         wr_cyc = 0, rd_cyc = 0;
   logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_ra = 8'h00;
   logic [7:0] tx_q[$];
   int         tx_cyc_q[$];
   int         tx_cnt = 0;
   logic [7:0] tx_held = 8'h00;
   logic       rd_pend = 1'b0;
   logic [7:0] rd_addr = 8'h00;

   always @(negedge clk) begin
      i_Reg_RData = rd_pend ? (rd_addr ^ 8'hE3) : 8'hEE;
      rd_pend     = o_Reg_Rd;
      rd_addr     = o_Reg_Addr;
      if (o_Reg_Wr) begin
         wr_n++; last_wa = o_Reg_Addr; last_wd = o_Reg_WData; wr_cyc = cyc;
      end
      if (o_Reg_Rd) begin
         rd_n++; last_ra = o_Reg_Addr; rd_cyc = cyc;
      end
      if (o_Err_Timeout) to_n++;
      if (o_Err_Overrun) ov_n++;
      i_TX_Done = 1'b0;
      if (tx_cnt > 0) begin
         if (o_TX_Byte !== tx_held) unstable_n++;
         tx_cnt--;
         if (tx_cnt == 0) begin
            i_TX_Active = 1'b0;
            i_TX_Done   = 1'b1;
         end
      end
      if (o_TX_DV) begin
         if (i_TX_Active) dvact_n++;
         tx_q.push_back(o_TX_Byte);
         tx_cyc_q.push_back(cyc);
         tx_held     = o_TX_Byte;
         i_TX_Active = 1'b1;
         tx_cnt      = TX_LEN;
      end
   end

   // ---------------- checking ----------------
   int checks = 0, failures = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   int last_dv_cyc = 0;

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      i_RX_DV = 1'b1; i_RX_Byte = b; last_dv_cyc = cyc;
      @(negedge clk);
      i_RX_DV = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
      logic [7:0] f [FRAME_LEN];
      f[0] = SYNC_BYTE; f[1] = c; f[2] = a; f[3] = d; f[4] = k;
      for (int i = 0; i < FRAME_LEN; i++) send_byte(f[i], 0);
   endtask

   // Wait (bounded) for nb response bytes beyond base and a quiet controller,
   // then linger to catch any extra byte.
   task automatic wait_resp(input string tag, input int base, input int nb);
      int k = 0;
      while (!((tx_q.size() >= base + nb) && !o_Busy && !i_TX_Active) && k < 600) begin
         @(negedge clk); k++;
      end
      chk_eq({tag, "_done"}, (k < 600), 1'b1);
      repeat (30) @(negedge clk);
      chk_eq({tag, "_nbytes"}, tx_q.size() - base, nb);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk_eq({tag, "_tx_dv"},   o_TX_DV, 0);
      chk_eq({tag, "_tx_byte"}, o_TX_Byte, 0);
      chk_eq({tag, "_wr"},      o_Reg_Wr, 0);
      chk_eq({tag, "_rd"},      o_Reg_Rd, 0);
      chk_eq({tag, "_addr"},    o_Reg_Addr, 0);
      chk_eq({tag, "_wdata"},   o_Reg_WData, 0);
      chk_eq({tag, "_busy"},    o_Busy, 0);
      chk_eq({tag, "_err_to"},  o_Err_Timeout, 0);
      chk_eq({tag, "_err_ov"},  o_Err_Overrun, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, b_wr, b_rd, b_to, b_ov, chk_c, k;

      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // write
      base = tx_q.size(); b_wr = wr_n; b_rd = rd_n;
      send_frame(8'h01, 8'h10, 8'h5A, 8'h4B);
      chk_c = last_dv_cyc;
      wait_resp("wr", base, 1);
      chk_eq("wr_count", wr_n - b_wr, 1);
      chk_eq("wr_rd_count", rd_n - b_rd, 0);
      chk_eq("wr_addr", last_wa, 8'h10);
      chk_eq("wr_data", last_wd, 8'h5A);
      chk_eq("wr_strobe_lat", wr_cyc - chk_c, 1);
      chk_eq("wr_ack", tx_q[base], 8'h06);
      chk_eq("wr_ack_lat", tx_cyc_q[base] - chk_c, 2);
      chk_eq("wr_busy_end", o_Busy, 0);

      // read
      base = tx_q.size(); b_wr = wr_n; b_rd = rd_n;
      send_frame(8'h02, 8'h20, 8'h00, 8'h22);
      chk_c = last_dv_cyc;
      wait_resp("rd", base, 2);
      chk_eq("rd_count", rd_n - b_rd, 1);
      chk_eq("rd_wr_count", wr_n - b_wr, 0);
      chk_eq("rd_addr", last_ra, 8'h20);
      chk_eq("rd_strobe_lat", rd_cyc - chk_c, 1);
      chk_eq("rd_ack", tx_q[base], 8'h06);
      chk_eq("rd_data", tx_q[base+1], 8'hC3);
      chk_eq("rd_ack_lat", tx_cyc_q[base] - chk_c, 3);
      chk_eq("rd_data_after_done", tx_cyc_q[base+1] - tx_cyc_q[base], TX_LEN + 1);

      // bad checksum
      base = tx_q.size(); b_wr = wr_n; b_rd = rd_n;
      send_frame(8'h01, 8'h10, 8'h5A, 8'h00);
      chk_c = last_dv_cyc;
      wait_resp("badchk", base, 1);
      chk_eq("badchk_nak", tx_q[base], 8'h15);
      chk_eq("badchk_nak_lat", tx_cyc_q[base] - chk_c, 2);
      chk_eq("badchk_no_access", (wr_n - b_wr) + (rd_n - b_rd), 0);

      // unknown command
      base = tx_q.size(); b_wr = wr_n; b_rd = rd_n;
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);
      wait_resp("badcmd", base, 1);
      chk_eq("badcmd_nak", tx_q[base], 8'h15);
      chk_eq("badcmd_no_access", (wr_n - b_wr) + (rd_n - b_rd), 0);

      // garbage before a valid frame
      base = tx_q.size(); b_wr = wr_n;
      send_byte(8'h3C, 0);
      send_byte(8'h11, 0);
      chk_eq("garbage_idle", o_Busy, 0);
      send_frame(8'h01, 8'h10, 8'h5A, 8'h4B);
      wait_resp("garbage", base, 1);
      chk_eq("garbage_wr_count", wr_n - b_wr, 1);
      chk_eq("garbage_ack", tx_q[base], 8'h06);

      // timeout after SYNC, CMD; then a write succeeds
      base = tx_q.size(); b_wr = wr_n; b_to = to_n;
      send_byte(SYNC_BYTE, 0);
      send_byte(8'h01, TO + 10);
      chk_eq("to_count", to_n - b_to, 1);
      chk_eq("to_no_tx", tx_q.size() - base, 0);
      chk_eq("to_busy", o_Busy, 0);
      chk_eq("to_no_wr", wr_n - b_wr, 0);
      send_frame(8'h01, 8'h33, 8'h44, 8'h76);
      wait_resp("to_after", base, 1);
      chk_eq("to_after_wr", wr_n - b_wr, 1);
      chk_eq("to_after_addr", last_wa, 8'h33);
      chk_eq("to_after_data", last_wd, 8'h44);
      chk_eq("to_after_ack", tx_q[base], 8'h06);

      // byte landing exactly on the terminal cycle is accepted
      base = tx_q.size(); b_wr = wr_n; b_to = to_n;
      send_byte(SYNC_BYTE, TO - 2);
      send_byte(8'h01, 0);
      send_byte(8'h10, 0);
      send_byte(8'h5A, 0);
      send_byte(8'h4B, 0);
      wait_resp("tc_edge", base, 1);
      chk_eq("tc_edge_no_to", to_n - b_to, 0);
      chk_eq("tc_edge_wr", wr_n - b_wr, 1);
      chk_eq("tc_edge_ack", tx_q[base], 8'h06);

      // one cycle later the timeout wins and the byte is discarded in IDLE
      base = tx_q.size(); b_to = to_n;
      send_byte(SYNC_BYTE, TO - 1);
      send_byte(8'h01, 10);
      chk_eq("tc_late_to", to_n - b_to, 1);
      chk_eq("tc_late_busy", o_Busy, 0);
      chk_eq("tc_late_no_tx", tx_q.size() - base, 0);

      // overrun during TX_ACK_WAIT
      base = tx_q.size(); b_wr = wr_n; b_ov = ov_n;
      send_frame(8'h01, 8'h10, 8'h5A, 8'h4B);
      k = 0;
      while (tx_q.size() == base && k < 100) begin
         @(negedge clk); k++;
      end
      chk_eq("ov_ack_started", (k < 100), 1'b1);
      send_byte(8'h55, 0);
      wait_resp("ov", base, 1);
      chk_eq("ov_count", ov_n - b_ov, 1);
      chk_eq("ov_ack", tx_q[base], 8'h06);
      chk_eq("ov_wr", wr_n - b_wr, 1);

      // reset after GET_ADDR, then a read frame succeeds
      base = tx_q.size(); b_rd = rd_n; b_wr = wr_n;
      send_byte(SYNC_BYTE, 0);
      send_byte(8'h02, 0);
      send_byte(8'h44, 0);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(8'h02, 8'h20, 8'h00, 8'h22);
      wait_resp("postrst", base, 2);
      chk_eq("postrst_rd", rd_n - b_rd, 1);
      chk_eq("postrst_no_wr", wr_n - b_wr, 0);
      chk_eq("postrst_ack", tx_q[base], 8'h06);
      chk_eq("postrst_data", tx_q[base+1], 8'hC3);

      chk_eq("tx_dv_while_active", dvact_n, 0);
      chk_eq("tx_byte_unstable", unstable_n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
